msx_sdram_sequencer: RTL and testbench
======================================

// Module: msx_sdram_sequencer
// PURPOSE
//  Sits directly downstream of msx_slots. Converts its level-style RAM request (sdram_ce/ram_rnw/ram_addr/ram_din)
//  into exactly one req/ack transaction per CPU memory cycle towards the SDRAM controller.
//  Posts writes into a small buffer so the CPU does not stall on them; stalls the CPU (cpu_wait) on reads.
//  Returns read data on ram_dout, forwarding from the write buffer on an address match; guards every access with a timeout.
// PARAMETERS
//  ADDR_W      27   SDRAM byte address width (matches msx_slots ram_addr)
//  WBUF_DEPTH  2    posted-write entries; power of two, >=2
//  TIMEOUT     64   clk_sys cycles an issued sd_req may wait for sd_ack before abort
// PORTS
//  clk_sys      in   1       system clock
//  reset        in   1       synchronous, active-high
//  cpu_req      in   1       1-cycle strobe: new CPU memory cycle starts (cpu_bus.req)
//  sdram_ce     in   1       from msx_slots: cycle targets SDRAM
//  ram_rnw      in   1       from msx_slots: 1=read (also 1 for read-only blocks)
//  ram_addr     in   ADDR_W  from msx_slots
//  ram_din      in   8       from msx_slots
//  ram_dout     out  8       read data back to msx_slots
//  cpu_wait     out  1       CPU wait request
//  sd_req       out  1       request to SDRAM controller, held until sd_ack
//  sd_we        out  1       1=write transaction
//  sd_addr      out  ADDR_W  transaction address
//  sd_din       out  8       write data
//  sd_ack       in   1       1-cycle completion strobe; read data valid on sd_dout same cycle
//  sd_dout      in   8       read data
//  timeout_err  out  1       sticky: some transaction aborted by timeout; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except ram_dout=8'hFF; buffer empty; FSM IDLE; timeout counter 0.
//  - Accept: access taken only when cpu_req & sdram_ce in IDLE; cpu_req while not IDLE is ignored (CPU is held by cpu_wait).
//  - Write accept, buffer not full: push {addr,data}; cpu_wait stays 0.
//  - Write accept, buffer full: FSM WR_STALL; cpu_wait=1 from next cycle; push when a slot frees; back to IDLE, cpu_wait=0 next cycle.
//  - Read accept, newest buffer entry with matching addr: ram_dout=its data next cycle, no wait, no SDRAM access.
//  - Read accept, no match: FSM RD_DRAIN (cpu_wait=1 from next cycle) until buffer empty and no write outstanding,
//    then RD_ISSUE (sd_req=1, sd_we=0); on sd_ack latch sd_dout into ram_dout -> RD_DONE; cpu_wait=0 in the cycle after RD_DONE -> IDLE.
//    Read latency with empty buffer and 1-cycle ack: cpu_wait high exactly 3 cycles.
//  - Drain: whenever no transaction is outstanding and the buffer is non-empty (in any state except RD_ISSUE),
//    issue the head entry (sd_req=1, sd_we=1); pop on sd_ack. Writes retire in FIFO order.
//  - Handshake: sd_addr/sd_din/sd_we stable while sd_req=1; sd_req drops the cycle after sd_ack;
//    at most one outstanding transaction; a new sd_req may rise no earlier than 1 cycle after the drop.
//  - Timeout: counter counts while sd_req=1 and clears on sd_ack or drop. On reaching TIMEOUT: drop sd_req, set timeout_err;
//    aborted write is popped (lost); aborted read returns 8'hFF and releases cpu_wait as on a normal completion.
//  - Simultaneous push+pop on the same cycle is legal and leaves the count unchanged; a full buffer plus pop permits push that cycle.
//  - Read-only blocks arrive as ram_rnw=1 and are handled as reads, never as writes.
//  - Reset mid-transaction: sd_req drops next edge; buffered writes are discarded; the controller tolerates an abandoned request.
//  - sdram_ce=0 on cpu_req: no action; ram_dout holds its last value.
// STRUCTURE
//  - MSX package: seq_state_t enum {IDLE, WR_STALL, RD_DRAIN, RD_ISSUE, RD_DONE}; wbuf_entry_t struct {addr[ADDR_W], data[8]}.
//  - Sub-module msx_sdram_wbuf: WBUF_DEPTH FIFO of wbuf_entry_t with push/pop/full/empty/head
//    and a newest-entry address-compare output for forwarding.
//  - Top level holds FSM, issue/handshake register, timeout counter, ram_dout register.
// TESTING
//  1 Write 0x1234<-0x5A, ack 2 cycles after req -> cpu_wait never 1; sd_req/sd_we=1 with addr 0x1234 data 0x5A; pop after ack.
//  2 Write 0x10<-0x11, write 0x20<-0x22, write 0x30<-0x33, ack held off -> third write stalls (cpu_wait=1) until first ack; SDRAM sees 0x10,0x20,0x30 in order.
//  3 Write 0x40<-0xA5 (ack held), read 0x40 -> ram_dout=0xA5 next cycle, cpu_wait=0, no read transaction issued.
//  4 Empty buffer, read 0x100, sd_ack 1 cycle after req with sd_dout=0x3C -> ram_dout=0x3C; cpu_wait high exactly 3 cycles.
//  5 Read 0x200, never ack -> sd_req drops after 64 cycles; timeout_err=1; ram_dout=0xFF; cpu_wait released; next access proceeds normally.
//  6 Reset asserted while sd_req=1 with 2 entries buffered -> next cycle sd_req=0, cpu_wait=0, buffer empty, timeout_err=0.

Source files
------------

// File: rtl/msx_sdram_pkg.sv
// Shared types for the MSX SDRAM request sequencer and its posted-write buffer.
package msx_sdram_pkg;
    localparam int SD_ADDR_W = 27;

    typedef enum logic [2:0] {
        IDLE,
        WR_STALL,
        RD_DRAIN,
        RD_ISSUE,
        RD_DONE
    } seq_state_t;

    typedef struct packed {
        logic [SD_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } wbuf_entry_t;
endpackage

// File: rtl/msx_sdram_wbuf.sv
// Posted-write FIFO; also compares the newest entry's address so reads can forward.
module msx_sdram_wbuf
    import msx_sdram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  wbuf_entry_t          din,
    input  logic [SD_ADDR_W-1:0] cmp_addr,
    output logic                 full,
    output logic                 empty,
    output wbuf_entry_t          head,
    output logic                 hit,
    output logic [7:0]           hit_data
);
    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   last_ptr;
    logic [PW:0]     count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign last_ptr = wr_ptr - 1'b1;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign hit      = !empty && (mem[last_ptr].addr == cmp_addr);
    assign hit_data = mem[last_ptr].data;
endmodule

// File: rtl/msx_sdram_sequencer.sv
// Turns msx_slots level-style RAM cycles into single req/ack SDRAM transactions,
// posting writes, stalling reads, forwarding buffered data and aborting on timeout.
module msx_sdram_sequencer
    import msx_sdram_pkg::*;
#(
    parameter int ADDR_W     = SD_ADDR_W,
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              sdram_ce,
    input  logic              ram_rnw,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic              cpu_wait,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    input  logic              sd_ack,
    input  logic [7:0]        sd_dout,
    output logic              timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t  state, state_nxt;
    wbuf_entry_t pend, cpu_entry, push_entry, head;
    logic        push, pop, full, empty, hit, fwd;
    logic [7:0]  hit_data;
    logic [TW-1:0] tmo;
    logic        accept, ack_v, tmo_hit, done, rd_done, rd_issue, wr_issue;

    assign cpu_entry = '{addr: SD_ADDR_W'(ram_addr), data: ram_din};
    assign accept    = (state == IDLE) && cpu_req && sdram_ce;
    assign ack_v     = sd_req && sd_ack;
    assign tmo_hit   = sd_req && !sd_ack && (tmo == TW'(TIMEOUT - 1));
    assign done      = ack_v || tmo_hit;
    assign pop       = done && sd_we;
    assign rd_done   = done && !sd_we && (state == RD_ISSUE);
    assign rd_issue  = (state == RD_DRAIN) && empty && !sd_req;
    // Buffered writes go out whenever the bus is free, except while a read owns it.
    assign wr_issue  = !sd_req && !empty && (state != RD_ISSUE);
    assign cpu_wait  = (state == WR_STALL) || (state == RD_DRAIN) || (state == RD_ISSUE);

    msx_sdram_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk      (clk_sys),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (push_entry),
        .cmp_addr (SD_ADDR_W'(ram_addr)),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .hit      (hit),
        .hit_data (hit_data)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        fwd        = 1'b0;
        push_entry = cpu_entry;
        case (state)
            IDLE: if (accept) begin
                if (!ram_rnw) begin
                    // A slot freed by this cycle's pop is usable immediately.
                    if (!full || pop) push = 1'b1;
                    else              state_nxt = WR_STALL;
                end else if (hit) begin
                    fwd = 1'b1;
                end else begin
                    state_nxt = RD_DRAIN;
                end
            end
            WR_STALL: begin
                push_entry = pend;
                if (!full || pop) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_DRAIN: if (rd_issue) state_nxt = RD_ISSUE;
            RD_ISSUE: if (rd_done)  state_nxt = RD_DONE;
            RD_DONE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_req      <= 1'b0;
            sd_we       <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            tmo         <= '0;
            timeout_err <= 1'b0;
            ram_dout    <= 8'hFF;
            pend        <= '0;
        end else begin
            if (accept) pend <= cpu_entry;

            if (done) begin
                sd_req <= 1'b0;
                tmo    <= '0;
                if (tmo_hit) timeout_err <= 1'b1;
            end else if (sd_req) begin
                tmo <= tmo + 1'b1;
            end else if (rd_issue) begin
                sd_req  <= 1'b1;
                sd_we   <= 1'b0;
                sd_addr <= ADDR_W'(pend.addr);
                sd_din  <= pend.data;
            end else if (wr_issue) begin
                sd_req  <= 1'b1;
                sd_we   <= 1'b1;
                sd_addr <= ADDR_W'(head.addr);
                sd_din  <= head.data;
            end

            if (rd_done)  ram_dout <= ack_v ? sd_dout : 8'hFF;
            else if (fwd) ram_dout <= hit_data;
        end
    end
endmodule

// File: tb/tb_msx_sdram_sequencer.sv
// Scoreboarded bench: expected SDRAM transactions are queued as CPU cycles are driven
// and checked as each sd_req rises; a small responder models the controller.
module tb_msx_sdram_sequencer;
    localparam int AW = 27;

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_req, sdram_ce, ram_rnw;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din, ram_dout;
    logic          cpu_wait, sd_req, sd_we, sd_ack, timeout_err;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din, sd_dout;

    txn_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ack_dly = 1;
    bit   ack_hold = 1'b0;
    logic [7:0] rd_data = 8'h00;

    always #5 clk_sys = ~clk_sys;

    msx_sdram_sequencer dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .sdram_ce    (sdram_ce),
        .ram_rnw     (ram_rnw),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .cpu_wait    (cpu_wait),
        .sd_req      (sd_req),
        .sd_we       (sd_we),
        .sd_addr     (sd_addr),
        .sd_din      (sd_din),
        .sd_ack      (sd_ack),
        .sd_dout     (sd_dout),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_txn();
        txn_t t;
        if (exp_q.size() == 0) begin
            chk("sd_unexpected", {31'd0, sd_req}, 32'd0);
        end else begin
            t = exp_q.pop_front();
            chk("sd_we", {31'd0, sd_we}, {31'd0, t.we});
            chk("sd_addr", 32'(sd_addr), 32'(t.addr));
            if (t.we) chk("sd_din", {24'd0, sd_din}, {24'd0, t.data});
        end
    endtask

    // Controller model: acks ack_dly cycles after it first sees sd_req.
    initial begin
        bit seen;
        int cnt;
        seen = 1'b0;
        cnt = 0;
        sd_ack = 1'b0;
        sd_dout = 8'h00;
        forever begin
            @(negedge clk_sys);
            sd_ack = 1'b0;
            if (sd_req && !reset) begin
                if (!seen) begin
                    seen = 1'b1;
                    cnt = 0;
                    check_txn();
                end else begin
                    cnt++;
                end
                if (!ack_hold && cnt >= ack_dly) begin
                    sd_ack = 1'b1;
                    sd_dout = rd_data;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic wait_free();
        for (int i = 0; i < 500 && cpu_wait; i++) @(negedge clk_sys);
        if (cpu_wait) chk("cpu_wait_stuck", 32'd1, 32'd0);
        @(negedge clk_sys);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (exp_q.size() != 0 || sd_req); i++) @(negedge clk_sys);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic cpu_cycle(input bit rnw, input bit ce, input logic [AW-1:0] a, input logic [7:0] d);
        wait_free();
        cpu_req = 1'b1; sdram_ce = ce; ram_rnw = rnw; ram_addr = a; ram_din = d;
        @(negedge clk_sys);
        cpu_req = 1'b0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
        txn_t t;
        t.we = 1'b1; t.addr = a; t.data = d;
        exp_q.push_back(t);
        cpu_cycle(1'b0, 1'b1, a, d);
    endtask

    // Read that must reach SDRAM; returns cycles of cpu_wait and of sd_req seen.
    task automatic cpu_rd_sd(input logic [AW-1:0] a, output int wcnt, output int rcnt);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.data = 8'h00;
        exp_q.push_back(t);
        cpu_cycle(1'b1, 1'b1, a, 8'h00);
        wcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!cpu_wait) break;
            wcnt++;
            if (sd_req) rcnt++;
            @(negedge clk_sys);
        end
    endtask

    initial begin
        int wc, rc;
        logic [7:0] held;
        reset = 1'b1;
        cpu_req = 1'b0; sdram_ce = 1'b0; ram_rnw = 1'b1; ram_addr = '0; ram_din = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_sd_req", {31'd0, sd_req}, 32'd0);
        chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        chk("rst_tmo_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'hFF);
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: single posted write, ack two cycles after request
        ack_dly = 2;
        cpu_wr(27'h1234, 8'h5A);
        wc = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_wait) wc++;
            @(negedge clk_sys);
        end
        chk("t1_no_wait", 32'(wc), 32'd0);
        drain();
        chk("t1_req_low", {31'd0, sd_req}, 32'd0);

        // 2: third write into a full buffer stalls until the first ack
        ack_dly = 1;
        ack_hold = 1'b1;
        cpu_wr(27'h10, 8'h11);
        cpu_wr(27'h20, 8'h22);
        chk("t2_no_wait2", {31'd0, cpu_wait}, 32'd0);
        cpu_wr(27'h30, 8'h33);
        chk("t2_stall", {31'd0, cpu_wait}, 32'd1);
        repeat (5) @(negedge clk_sys);
        chk("t2_stall_hold", {31'd0, cpu_wait}, 32'd1);
        ack_hold = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("t2_release", {31'd0, cpu_wait}, 32'd0);
        drain();

        // 3: read hits the newest posted write while its ack is held
        ack_hold = 1'b1;
        cpu_wr(27'h40, 8'hA5);
        repeat (3) @(negedge clk_sys);
        cpu_cycle(1'b1, 1'b1, 27'h40, 8'h00);
        chk("t3_fwd_data", {24'd0, ram_dout}, 32'hA5);
        chk("t3_fwd_nowait", {31'd0, cpu_wait}, 32'd0);
        ack_hold = 1'b0;
        drain();

        // 4: plain read, empty buffer, 1-cycle ack
        rd_data = 8'h3C;
        cpu_rd_sd(27'h100, wc, rc);
        chk("t4_wait_cycles", 32'(wc), 32'd3);
        chk("t4_rdata", {24'd0, ram_dout}, 32'h3C);

        // chip enable low: no action, ram_dout held
        held = ram_dout;
        cpu_cycle(1'b1, 1'b0, 27'h555, 8'h00);
        chk("ce0_nowait", {31'd0, cpu_wait}, 32'd0);
        repeat (3) @(negedge clk_sys);
        chk("ce0_hold", {24'd0, ram_dout}, {24'd0, held});

        // 5: read never acked -> timeout abort
        ack_hold = 1'b1;
        cpu_rd_sd(27'h200, wc, rc);
        chk("t5_req_cycles", 32'(rc), 32'd64);
        chk("t5_wait_cycles", 32'(wc), 32'd65);
        chk("t5_tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("t5_rdata_ff", {24'd0, ram_dout}, 32'hFF);
        chk("t5_req_low", {31'd0, sd_req}, 32'd0);
        ack_hold = 1'b0;
        rd_data = 8'h77;
        cpu_rd_sd(27'h300, wc, rc);
        chk("t5_next_wait", 32'(wc), 32'd3);
        chk("t5_next_rdata", {24'd0, ram_dout}, 32'h77);
        chk("t5_err_sticky", {31'd0, timeout_err}, 32'd1);

        // 6: reset with one write outstanding and a second buffered
        ack_hold = 1'b1;
        cpu_wr(27'h500, 8'h55);
        cpu_cycle(1'b0, 1'b1, 27'h600, 8'h66);
        @(negedge clk_sys);
        chk("t6_req_before", {31'd0, sd_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("t6_req_drop", {31'd0, sd_req}, 32'd0);
        chk("t6_wait_clr", {31'd0, cpu_wait}, 32'd0);
        chk("t6_err_clr", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        ack_hold = 1'b0;
        @(negedge clk_sys);
        // a read of the discarded address must go to SDRAM with empty-buffer latency
        rd_data = 8'h99;
        cpu_rd_sd(27'h600, wc, rc);
        chk("t6_empty_wait", 32'(wc), 32'd3);
        chk("t6_rdata", {24'd0, ram_dout}, 32'h99);
        drain();

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
